// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions used by the fill and traceback paths:
// direction codes, score width, default scoring and matrix addressing.
package nw_pkg;

    localparam int SW = 9;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_LEFT = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;

    localparam int DEF_MATCH    = 1;
    localparam int DEF_MISMATCH = -1;
    localparam int DEF_GAP      = -1;

    typedef enum logic [2:0] {
        IDLE,
        RD_CUR,
        RD_DIAG,
        RD_UP,
        CAPT,
        DECIDE,
        EMIT,
        FIN
    } tb_state_e;

    // Row-major cell address in an (n+1)x(n+1) matrix.
    function automatic int addr_of(int i, int j, int n);
        return i * (n + 1) + j;
    endfunction

endpackage

// File: rtl/score_traceback_if.sv
// Direction-code stream between the traceback walker and the formatter.
// The master presents dir/dir_valid, the slave answers with dir_ready.
interface score_traceback_if;

    logic       dir_valid;
    logic       dir_ready;
    logic [1:0] dir;

    modport master (
        output dir_valid,
        output dir,
        input  dir_ready
    );

    modport slave (
        input  dir_valid,
        input  dir,
        output dir_ready
    );

endinterface

// File: rtl/tb_cell_decide.sv
// Picks the predecessor of one matrix cell from its stored neighbours.
// Operands are widened by one bit so the additions never wrap.
module tb_cell_decide
    import nw_pkg::*;
#(
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic signed [SW-1:0] cur_i,
    input  logic signed [SW-1:0] diag_i,
    input  logic signed [SW-1:0] up_i,
    input  logic [1:0]           a_i,
    input  logic [1:0]           b_i,
    output logic [1:0]           dir_o
);

    localparam int SX = SW + 1;
    localparam logic signed [SX-1:0] MA = SX'(MATCH);
    localparam logic signed [SX-1:0] MM = SX'(MISMATCH);
    localparam logic signed [SX-1:0] GP = SX'(GAP);

    logic signed [SX-1:0] cur_x, diag_x, up_x, sub_x;

    always_comb begin
        cur_x  = {cur_i[SW-1], cur_i};
        diag_x = {diag_i[SW-1], diag_i};
        up_x   = {up_i[SW-1], up_i};
        sub_x  = (a_i == b_i) ? MA : MM;
        if (cur_x == diag_x + sub_x) begin
            dir_o = DIR_DIAG;
        end else if (cur_x == up_x + GP) begin
            dir_o = DIR_UP;
        end else begin
            dir_o = DIR_LEFT;
        end
    end

endmodule

// File: rtl/score_traceback.sv
// Walks a filled score matrix from (N,N) back to (0,0), re-deriving each
// step from RAM scores and sequence characters, one code per handshake.
module score_traceback
    import nw_pkg::*;
#(
    parameter int N           = 5,
    parameter int MATCH       = DEF_MATCH,
    parameter int MISMATCH    = DEF_MISMATCH,
    parameter int GAP         = DEF_GAP,
    parameter int BitAddr     = $clog2(N + 1),
    parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 score_rd_en,
    output logic [addr_lenght:0] score_addr,
    input  logic signed [SW-1:0] score_data,
    output logic [BitAddr:0]     seq_a_addr,
    output logic [BitAddr:0]     seq_b_addr,
    input  logic [1:0]           seq_a_char,
    input  logic [1:0]           seq_b_char,
    score_traceback_if.master    dout,
    output logic [BitAddr:0]     cur_i,
    output logic [BitAddr:0]     cur_j,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = BitAddr + 1;
    localparam int AW = addr_lenght + 1;
    localparam logic [IW-1:0] ONE = IW'(1);

    tb_state_e            state_q;
    logic [IW-1:0]        i_q, j_q, ni_d, nj_d, sa_q, sb_q;
    logic [AW-1:0]        addr_q;
    logic                 rd_en_q, valid_q, busy_q, done_q;
    logic signed [SW-1:0] cur_q, diag_q, up_q;
    logic [1:0]           a_q, b_q, dir_q, dec_dir;

    tb_cell_decide #(
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP      (GAP)
    ) u_decide (
        .cur_i  (cur_q),
        .diag_i (diag_q),
        .up_i   (up_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .dir_o  (dec_dir)
    );

    // Cell reached once the pending code is accepted.
    always_comb begin
        ni_d = i_q;
        nj_d = j_q;
        unique case (1'b1)
            dir_q == DIR_DIAG: begin
                ni_d = i_q - ONE;
                nj_d = j_q - ONE;
            end
            dir_q == DIR_UP: ni_d = i_q - ONE;
            default:         nj_d = j_q - ONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cur_q   <= '0;
            diag_q  <= '0;
            up_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dir_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    i_q <= IW'(N);
                    j_q <= IW'(N);
                    if (N == 0) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RD_CUR;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        addr_q  <= AW'(addr_of(N, N, N));
                        sa_q    <= IW'(N - 1);
                        sb_q    <= IW'(N - 1);
                    end
                end
                RD_CUR: begin
                    state_q <= RD_DIAG;
                    rd_en_q <= 1'b1;
                    addr_q  <= AW'(addr_of(int'(i_q) - 1,
                                           int'(j_q) - 1, N));
                end
                RD_DIAG: begin
                    state_q <= RD_UP;
                    cur_q   <= score_data;
                    a_q     <= seq_a_char;
                    b_q     <= seq_b_char;
                    rd_en_q <= 1'b1;
                    addr_q  <= AW'(addr_of(int'(i_q) - 1,
                                           int'(j_q), N));
                end
                RD_UP: begin
                    state_q <= CAPT;
                    diag_q  <= score_data;
                end
                CAPT: begin
                    state_q <= DECIDE;
                    up_q    <= score_data;
                end
                DECIDE: begin
                    state_q <= EMIT;
                    dir_q   <= dec_dir;
                    valid_q <= 1'b1;
                end
                EMIT: if (dout.dir_ready) begin
                    valid_q <= 1'b0;
                    i_q     <= ni_d;
                    j_q     <= nj_d;
                    if (ni_d == '0 && nj_d == '0) begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (ni_d == '0 || nj_d == '0) begin
                        // Border cells need no scores: forced left/up.
                        dir_q   <= (ni_d == '0) ? DIR_LEFT : DIR_UP;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= RD_CUR;
                        rd_en_q <= 1'b1;
                        addr_q  <= AW'(addr_of(int'(ni_d),
                                               int'(nj_d), N));
                        sa_q    <= ni_d - ONE;
                        sb_q    <= nj_d - ONE;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign score_rd_en    = rd_en_q;
    assign score_addr     = addr_q;
    assign seq_a_addr     = sa_q;
    assign seq_b_addr     = sb_q;
    assign dout.dir_valid = valid_q;
    assign dout.dir       = dir_q;
    assign cur_i          = i_q;
    assign cur_j          = j_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: doc/score_traceback.md
Name: score_traceback

Overview:
- Read-side counterpart of the score-matrix manager. The manager is the writer/responder that fills the (N+1)x(N+1) score RAM; this block is the reader that consumes it.
- After matrix fill completes, it walks from cell (N,N) back to (0,0). It re-derives each step from stored scores and the two input sequences, and emits one direction code per step through a valid/ready stream.
- It sits between the score RAM read port and the alignment output/formatter.

Parameters:
- N, 5: sequence length; the matrix is (N+1)x(N+1).
- MATCH, 1: signed score for equal characters.
- MISMATCH, -1: signed score for unequal characters.
- GAP, -1: signed gap penalty.
- BitAddr, $clog2(N+1): width minus one of the i/j indices.
- addr_lenght, $clog2(((N+1)*(N+1))-1): width minus one of the score RAM address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- start  in  1  one-cycle pulse; begins traceback when idle.
- score_rd_en  out  1  score RAM read strobe.
- score_addr  out  addr_lenght+1  read address, equal to i*(N+1)+j.
- score_data  in  9  signed score, valid 1 cycle after the strobe.
- seq_a_addr  out  BitAddr+1  index i-1 into sequence A.
- seq_b_addr  out  BitAddr+1  index j-1 into sequence B.
- seq_a_char  in  2  character of A, valid 1 cycle after the address.
- seq_b_char  in  2  character of B, valid 1 cycle after the address.
- dir_valid  out  1  direction code available.
- dir_ready  in  1  downstream accepts the code.
- dir  out  2  direction code: 00 = diag (i-1,j-1), 01 = left (i,j-1), 10 = up (i-1,j). 11 is never emitted.
- cur_i, cur_j  out  BitAddr+1 each  cell currently being resolved.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last code is accepted.

Behaviour:
- Reset (async, rst=0): FSM returns to IDLE and all outputs are 0. This applies mid-operation too; the traceback is abandoned, no partial done is produced, and registers are reloaded on the next start.
- FSM states: IDLE, RD_CUR, RD_DIAG, RD_UP, CAPT, DECIDE, EMIT, FIN.
- IDLE: on start, load i=N and j=N, assert busy, go to RD_CUR. A start pulse in any other state is ignored.
- Interior cell (i>0, j>0), one read per cycle with the strobe high:
  - RD_CUR issues addr(i,j) and drives seq_a_addr=i-1, seq_b_addr=j-1.
  - RD_DIAG issues addr(i-1,j-1) and captures cur and both characters.
  - RD_UP issues addr(i-1,j) and captures diag.
  - CAPT captures up.
  - DECIDE selects the direction, registered. Priority: diag if cur == diag + (a==b ? MATCH : MISMATCH); else up if cur == up + GAP; else left.
  - EMIT drives dir_valid=1.
  - Result: first dir_valid occurs 5 cycles after leaving RD_CUR entry.
- Edge cells (i==0 or j==0) take no RAM reads; go straight to EMIT. i==0 with j>0 emits left; j==0 with i>0 emits up.
- Arithmetic: sign-extend operands to 10 bits before addition and compare at 10 bits, so overflow never aliases.
- Handshake in EMIT:
  - The code transfers when dir_valid && dir_ready.
  - dir and dir_valid hold stable until transfer, and no RAM reads occur meanwhile.
  - On transfer, update i/j per the code. If the new cell is (0,0), go to FIN; otherwise go to RD_CUR, or directly to EMIT for an edge cell.
- FIN: pulse done for 1 cycle, deassert busy, return to IDLE.
- Start with N=0 (cell already (0,0)): go to FIN immediately and emit zero codes.
- Number of codes: at least N, at most 2N.
- score_rd_en is low in every state except RD_CUR, RD_DIAG and RD_UP.

Decomposition:
- Shared package (nw_pkg):
  - direction code constants DIR_DIAG, DIR_LEFT, DIR_UP;
  - score width 9;
  - default scoring constants shared with the fill path;
  - an addr_of(i,j) function.
- One sub-module, tb_cell_decide: combinational compare of cur/diag/up/chars producing dir. It is reusable by the fill path's argmax check.

Test Plan:
- N=2, A="AC", B="AC" (A=0, C=1), RAM rows {0,-1,-2},{-1,1,0},{-2,0,2}, start -> codes diag, diag, then done; busy high for the duration.
- N=2, A="AC", B="CA", RAM rows {0,-1,-2},{-1,-1,0},{-2,0,-1} -> codes up (2,2->1,2), diag (->0,1), left (->0,0), then done.
- Backpressure on the first case: dir_ready low for 3 cycles in EMIT -> dir_valid stays 1, dir stays 00, score_rd_en stays 0, cur_i/cur_j unchanged.
- Tie priority, hand-loaded cell where cur equals both diag+MISMATCH and up+GAP -> diag emitted.
- start re-pulsed while busy -> ignored; the code sequence is identical to the undisturbed run.
- rst driven to 0 during RD_DIAG -> all outputs 0 immediately. After release, a new start reproduces the full correct sequence.
